// File: rtl/ldn_alu_wb_buffer_pkg.sv
// Shared types for the LDN ALU writeback buffer.
//   XLEN, TRANS_ID_BITS : datapath and scoreboard-id widths
//   fu_op               : functional-unit operator encoding (ALU subset incl. LDN ops)
//   ldn_wb_entry_t      : one queued writeback entry {is_ldn, trans_id, result}
//   is_ldn_op()         : true for the SIMD LDN operators counted on retirement
package ldn_alu_wb_buffer_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef enum logic [7:0] {
        ADD,
        SUB,
        ANDL,
        ORL,
        XORL,
        LDN_MIN,
        LDN_SUBUSAT,
        LDN_ADDUSAT,
        LDN_IDXMINCOMP,
        LDN_IDXMINUP,
        LDN_IDXMINUP2
    } fu_op;

    typedef struct packed {
        logic                     is_ldn;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [XLEN-1:0]          result;
    } ldn_wb_entry_t;

    function automatic logic is_ldn_op(input fu_op op);
        logic ldn;
        case (op)
            LDN_MIN, LDN_SUBUSAT, LDN_ADDUSAT,
            LDN_IDXMINCOMP, LDN_IDXMINUP, LDN_IDXMINUP2: ldn = 1'b1;
            default:                                    ldn = 1'b0;
        endcase
        return ldn;
    endfunction

endpackage

// File: rtl/ldn_alu_wb_buffer.sv
// Decoupling FIFO between the ALU and the integer writeback port.
// ALU results (with scoreboard trans_id) are queued so the ALU can keep issuing while the
// writeback arbiter stalls; retired LDN ops are counted for profiling.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   flush_i                       drop all queued entries
//   alu_valid_i / alu_ready_o     ALU-side handshake (ready = not full, registered state only)
//   alu_op_i, alu_trans_id_i,
//   alu_result_i                  incoming result and its tag
//   wb_valid_o / wb_ready_i       writeback handshake for the head entry
//   wb_trans_id_o, wb_result_o    head entry contents
//   occupancy_o                   number of entries held
//   clr_cnt_i                     synchronous clear of ldn_cnt_o (wins over increment)
//   ldn_cnt_o                     saturating count of retired LDN ops
module ldn_alu_wb_buffer
    import ldn_alu_wb_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       alu_valid_i,
    output logic                       alu_ready_o,
    input  fu_op                       alu_op_i,
    input  logic [TRANS_ID_BITS-1:0]   alu_trans_id_i,
    input  logic [XLEN-1:0]            alu_result_i,
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
    output logic [XLEN-1:0]            wb_result_o,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    input  logic                       clr_cnt_i,
    output logic [CNT_W-1:0]           ldn_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Pointers carry one extra MSB: equal low bits with differing MSB means full.
    logic [PTR_W:0]  wr_ptr_q, rd_ptr_q;
    ldn_wb_entry_t   mem_q [DEPTH];
    ldn_wb_entry_t   head;
    logic [CNT_W-1:0] cnt_q;
    logic            full, empty, push, pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign alu_ready_o = ~full;
    assign push        = alu_valid_i & ~full & ~flush_i;
    assign pop         = ~empty & wb_ready_i & ~flush_i;

    // No bypass: the head is always read from storage, so a push shows up one cycle later.
    assign head          = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign wb_valid_o    = ~empty;
    assign wb_trans_id_o = head.trans_id;
    assign wb_result_o   = head.result;
    assign occupancy_o   = wr_ptr_q - rd_ptr_q;
    assign ldn_cnt_o     = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            // Only the LDN-ness of the op is needed downstream, so the op is reduced here.
            mem_q[wr_ptr_q[PTR_W-1:0]] <= '{
                is_ldn:   is_ldn_op(alu_op_i),
                trans_id: alu_trans_id_i,
                result:   alu_result_i
            };
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_cnt_i) begin
            cnt_q <= '0;
        end else if (pop && head.is_ldn && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ldn_alu_wb_buffer.sv
// Bench for ldn_alu_wb_buffer: a queue-based reference model checked every cycle, a vector
// table for the basic push/pop/full behaviour, and hand sequences for streaming, flush,
// counter saturation/clear and asynchronous reset.
module tb_ldn_alu_wb_buffer;
    import ldn_alu_wb_buffer_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                     clk = 1'b0;
    logic                     rst_ni = 1'b0;
    logic                     flush = 1'b0;
    logic                     alu_valid = 1'b0;
    logic                     alu_ready;
    fu_op                     alu_op = ADD;
    logic [TRANS_ID_BITS-1:0] alu_id = '0;
    logic [XLEN-1:0]          alu_res = '0;
    logic                     wb_valid;
    logic                     wb_ready = 1'b0;
    logic [TRANS_ID_BITS-1:0] wb_id;
    logic [XLEN-1:0]          wb_res;
    logic [$clog2(DEPTH):0]   occupancy;
    logic                     clr_cnt = 1'b0;
    logic [CNT_W-1:0]         ldn_cnt;

    ldn_alu_wb_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .flush_i        (flush),
        .alu_valid_i    (alu_valid),
        .alu_ready_o    (alu_ready),
        .alu_op_i       (alu_op),
        .alu_trans_id_i (alu_id),
        .alu_result_i   (alu_res),
        .wb_valid_o     (wb_valid),
        .wb_ready_i     (wb_ready),
        .wb_trans_id_o  (wb_id),
        .wb_result_o    (wb_res),
        .occupancy_o    (occupancy),
        .clr_cnt_i      (clr_cnt),
        .ldn_cnt_o      (ldn_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TRANS_ID_BITS-1:0] id;
        logic [XLEN-1:0]          res;
        logic                     ldn;
    } exp_t;

    typedef struct {
        logic                     v;
        fu_op                     op;
        logic [TRANS_ID_BITS-1:0] id;
        logic [XLEN-1:0]          res;
        logic                     rdy;
        logic [1:0]               e_occ;
        logic                     e_ready;
        logic [CNT_W-1:0]         e_cnt;
    } vec_t;

    exp_t             sb_q[$];
    logic [CNT_W-1:0] m_cnt = '0;
    int               n_tests = 0;
    int               n_fail = 0;
    vec_t             tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic bench_is_ldn(input fu_op op);
        return op inside {LDN_MIN, LDN_SUBUSAT, LDN_ADDUSAT,
                          LDN_IDXMINCOMP, LDN_IDXMINUP, LDN_IDXMINUP2};
    endfunction

    task automatic check_state(input string tag);
        chk({tag, " wb_valid"}, 64'(wb_valid), 64'(sb_q.size() > 0));
        chk({tag, " occupancy"}, 64'(occupancy), 64'(sb_q.size()));
        chk({tag, " alu_ready"}, 64'(alu_ready), 64'(sb_q.size() < DEPTH));
        chk({tag, " ldn_cnt"}, 64'(ldn_cnt), 64'(m_cnt));
        if (sb_q.size() > 0) begin
            chk({tag, " wb_trans_id"}, 64'(wb_id), 64'(sb_q[0].id));
            chk({tag, " wb_result"}, wb_res, sb_q[0].res);
        end
    endtask

    // Drive one cycle of stimulus, check the current state against the model, advance both.
    task automatic cyc(input logic v, input fu_op op, input logic [TRANS_ID_BITS-1:0] id,
                       input logic [XLEN-1:0] res, input logic rdy, input logic fl,
                       input logic clr, input string tag);
        logic do_push, do_pop;
        exp_t e;
        alu_valid = v;
        alu_op    = op;
        alu_id    = id;
        alu_res   = res;
        wb_ready  = rdy;
        flush     = fl;
        clr_cnt   = clr;
        #1;
        check_state(tag);
        do_push = v && (sb_q.size() < DEPTH) && !fl;
        do_pop  = rdy && (sb_q.size() > 0) && !fl;
        if (clr) m_cnt = '0;
        else if (do_pop && sb_q[0].ldn && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
        if (fl) begin
            sb_q.delete();
        end else begin
            if (do_pop) void'(sb_q.pop_front());
            if (do_push) begin
                e.id  = id;
                e.res = res;
                e.ldn = bench_is_ldn(op);
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        flush     = 1'b0;
        clr_cnt   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b1, LDN_MIN, 3'd3, 64'h3F3F_0101_8080_0000, 1'b1, 2'd1, 1'b1, 4'd0};
        tbl[1] = '{1'b0, ADD,     3'd0, 64'h0,                   1'b1, 2'd0, 1'b1, 4'd1};
        tbl[2] = '{1'b0, ADD,     3'd0, 64'h0,                   1'b1, 2'd0, 1'b1, 4'd1};
        tbl[3] = '{1'b1, ADD,     3'd1, 64'h1111_0000_0000_0001, 1'b0, 2'd1, 1'b1, 4'd1};
        tbl[4] = '{1'b1, ADD,     3'd2, 64'h2222_0000_0000_0002, 1'b0, 2'd2, 1'b0, 4'd1};
        tbl[5] = '{1'b1, ADD,     3'd4, 64'h4444_0000_0000_0004, 1'b0, 2'd2, 1'b0, 4'd1};
        tbl[6] = '{1'b1, ADD,     3'd5, 64'h5555_0000_0000_0005, 1'b1, 2'd1, 1'b1, 4'd1};
        tbl[7] = '{1'b0, ADD,     3'd0, 64'h0,                   1'b1, 2'd0, 1'b1, 4'd1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset wb_valid", 64'(wb_valid), 64'd0);
        chk("reset occupancy", 64'(occupancy), 64'd0);
        chk("reset alu_ready", 64'(alu_ready), 64'd1);
        chk("reset ldn_cnt", 64'(ldn_cnt), 64'd0);
        chk("reset wb_trans_id", 64'(wb_id), 64'd0);
        chk("reset wb_result", wb_res, 64'd0);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Vector table: single LDN push/pop, empty pop, fill, drop on full, drain in order
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].v, tbl[i].op, tbl[i].id, tbl[i].res, tbl[i].rdy, 1'b0, 1'b0,
                $sformatf("vec%0d", i));
            chk($sformatf("vec%0d occupancy", i), 64'(occupancy), 64'(tbl[i].e_occ));
            chk($sformatf("vec%0d alu_ready", i), 64'(alu_ready), 64'(tbl[i].e_ready));
            chk($sformatf("vec%0d ldn_cnt", i), 64'(ldn_cnt), 64'(tbl[i].e_cnt));
        end

        // Streaming push+pop at occupancy 1
        cyc(1'b1, SUB, 3'd0, 64'hA000_0000_0000_0000, 1'b0, 1'b0, 1'b0, "stream0");
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, (i % 2 == 0) ? XORL : ORL, 3'((i + 1) % 8),
                64'hA000_0000_0000_0000 | 64'(i + 1), 1'b1, 1'b0, 1'b0, "stream");
            chk("stream occupancy", 64'(occupancy), 64'd1);
        end
        cyc(1'b0, ADD, 3'd0, 64'h0, 1'b1, 1'b0, 1'b0, "stream drain");
        chk("stream drained", 64'(occupancy), 64'd0);

        // Flush with full buffer and a same-cycle push/pop
        cyc(1'b1, LDN_MIN, 3'd6, 64'h6666, 1'b0, 1'b0, 1'b0, "flush fill");
        cyc(1'b1, LDN_IDXMINUP, 3'd7, 64'h7777, 1'b0, 1'b0, 1'b0, "flush fill");
        cyc(1'b1, LDN_MIN, 3'd1, 64'h1234, 1'b1, 1'b1, 1'b0, "flush");
        chk("flush occupancy", 64'(occupancy), 64'd0);
        chk("flush wb_valid", 64'(wb_valid), 64'd0);
        chk("flush ldn_cnt", 64'(ldn_cnt), 64'd1);

        // Counter saturation, then clear with a simultaneous LDN pop
        for (int i = 0; i < 40 && m_cnt != CNT_MAX; i++) begin
            cyc(1'b1, LDN_ADDUSAT, 3'(i), 64'(i) << 8, 1'b1, 1'b0, 1'b0, "sat ramp");
        end
        cyc(1'b1, LDN_ADDUSAT, 3'd2, 64'hBEEF, 1'b1, 1'b0, 1'b0, "sat hold");
        cyc(1'b1, LDN_ADDUSAT, 3'd3, 64'hCAFE, 1'b1, 1'b0, 1'b0, "sat hold");
        chk("sat ldn_cnt", 64'(ldn_cnt), 64'hF);
        cyc(1'b0, ADD, 3'd0, 64'h0, 1'b1, 1'b0, 1'b1, "clr");
        chk("clr ldn_cnt", 64'(ldn_cnt), 64'd0);

        // Asynchronous reset mid-operation
        cyc(1'b1, LDN_SUBUSAT, 3'd5, 64'h5151, 1'b0, 1'b0, 1'b0, "rst fill");
        cyc(1'b0, ADD, 3'd0, 64'h0, 1'b1, 1'b0, 1'b0, "rst pop");
        cyc(1'b1, ADD, 3'd1, 64'h1, 1'b0, 1'b0, 1'b0, "rst fill");
        cyc(1'b1, ADD, 3'd2, 64'h2, 1'b0, 1'b0, 1'b0, "rst fill");
        chk("pre-reset ldn_cnt", 64'(ldn_cnt), 64'd1);
        rst_ni = 1'b0;
        #2;
        chk("async reset occupancy", 64'(occupancy), 64'd0);
        chk("async reset wb_valid", 64'(wb_valid), 64'd0);
        chk("async reset alu_ready", 64'(alu_ready), 64'd1);
        chk("async reset ldn_cnt", 64'(ldn_cnt), 64'd0);
        sb_q.delete();
        m_cnt = '0;
        #2;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, LDN_IDXMINUP2, 3'd4, 64'h4242, 1'b1, 1'b0, 1'b0, "post reset");
        cyc(1'b0, ADD, 3'd0, 64'h0, 1'b1, 1'b0, 1'b0, "post reset");
        cyc(1'b0, ADD, 3'd0, 64'h0, 1'b1, 1'b0, 1'b0, "post reset");
        chk("post reset ldn_cnt", 64'(ldn_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
